llc_txsched: RTL and testbench
==============================

# llc_txsched

Transmit mailbox scheduler on the CPU side of the logic link control. It holds NMBX transmit mailboxes and selects the pending one that wins CAN arbitration (lowest arbitration key). It presents that mailbox to the LLC as `traregbit`/`txid`, then tracks the attempt through `load`, `sucftranc` and `resettra`. It is the transmit-side counterpart of the receive acceptance filter: instead of matching an incoming ID, it orders outgoing IDs.

## Interface
Parameters:
- NMBX, 4, number of mailboxes; power of two, 2..8
- IW, log2(NMBX) (2 at default), width of `txidx`

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- initreqr  in  1  CPU init request; synchronous clear of all state while high
- reqset  in  NMBX  per-mailbox transmit request pulse (sets pending)
- abtset  in  NMBX  per-mailbox abort request pulse
- mbxid  in  29*NMBX  mailbox IDs; mailbox i occupies bits [29i+28:29i]
- mbxext  in  NMBX  mailbox i uses extended format
- load  in  1  LLC pulse: attempt started, shift register loaded
- sucftranc  in  1  MAC pulse: successful transmission
- resettra  in  1  LLC pulse: attempt ended without success (arbitration lost or error)
- traregbit  out  1  transmit request toward the LLC
- txid  out  29  ID of the selected mailbox
- txext  out  1  extended flag of the selected mailbox
- txidx  out  IW  index of the selected mailbox
- pending  out  NMBX  pending flags
- busy  out  1  attempt in progress (state XFER)
- txdone  out  NMBX  one-cycle pulse: mailbox transmitted
- txabrt  out  NMBX  one-cycle pulse: mailbox aborted
- txfail  out  NMBX  one-cycle pulse: single-shot failure; constant 0 without the macro

## Operation
- **Arbitration key** (30 bit): `{id[28:18], ext, ext ? id[17:0] : 18'b0}`.
  - The lowest key wins.
  - On equal keys, the lowest index wins.
  - Only pending mailboxes compete.
- **State machine:** IDLE, SELECT, REQ, XFER.
- **IDLE:** if any pending bit is set, go to SELECT.
- **SELECT:**
  - Compute the winner.
  - Register `txid`, `txext` and `txidx`.
  - Go to REQ; if nothing is pending, go to IDLE.
- **REQ** (`traregbit` = 1):
  - `load` goes to XFER; selection is locked.
  - Before `load`: if a mailbox with a lower key becomes pending, go to SELECT.
  - Before `load`: if the selected mailbox is aborted, clear it, pulse `txabrt`, go to SELECT.
  - `load` in the same cycle as either event: `load` wins and the block goes to XFER; a locked abort becomes abort-pending.
- **XFER** (`traregbit` = 1, `busy` = 1):
  - `sucftranc`: clear `pending[txidx]`, pulse `txdone[txidx]`, go to IDLE. This also applies when abort-pending is set; success is reported and abort-pending is cleared.
  - `resettra` with abort-pending set: clear the pending bit, pulse `txabrt`, go to IDLE.
  - `resettra` otherwise: pending is kept (retry), go to IDLE.
  - `sucftranc` and `resettra` in the same cycle: success wins.
- **Pending bit updates:**
  - `reqset[i]` on an already pending mailbox has no effect.
  - `reqset[i]` and `abtset[i]` in the same cycle: abort wins, pending ends at 0, and `txabrt[i]` pulses only if the mailbox was pending.
  - `abtset` on a non-pending mailbox has no effect.
  - `abtset` on a non-locked pending mailbox: clear it next cycle and pulse `txabrt`.
- `mbxid` and `mbxext` are sampled only in SELECT. CPU changes after SELECT take effect only on the next SELECT.
- **initreqr:** clears pending and abort-pending, returns to IDLE, and drives every output to its reset value. No pulses are generated.

## Timing
- Reset values: all outputs 0; state IDLE; pending 0.
- Latency from `reqset` in IDLE (cycle n):
  - pending = 1 at n+1
  - SELECT at n+1
  - `traregbit` = 1 with valid `txid` at n+2
- Preemption in REQ: `traregbit` drops for exactly one cycle (SELECT), then rises with the new `txid`.
- After XFER completes: `traregbit` is 0 for at least one cycle (IDLE), then SELECT, then REQ. Minimum gap between attempts is 2 cycles.
- `txdone`, `txabrt` and `txfail` pulses are registered and appear the cycle after the causing event.
- An asynchronous reset mid-XFER returns all outputs to 0 immediately.

## Configuration
- Macro: `LLC_TXSCHED_SINGLESHOT_EN`.
- **Defined:** `resettra` in XFER without abort-pending clears `pending[txidx]` and pulses `txfail[txidx]`. There is no automatic retransmission.
- **Undefined:** the failed mailbox stays pending and is re-arbitrated; `txfail` is tied to 0.

## Test plan
- **Single request:** `mbxid[1]` = 0x123 standard; `reqset[1]` → `traregbit` at +2, `txidx` = 1, `txid` = 0x123. Then `load`, then `sucftranc` → `txdone[1]` pulse, pending = 0, `traregbit` = 0.
- **Priority:**
  - Mailbox 0: standard base 0x100. Mailbox 2: standard base 0x080. Both requested together → `txidx` = 2.
  - Mailbox 3: extended with base 0x080; mailbox 2 still pending → mailbox 2 still wins.
  - Equal keys in mailboxes 1 and 3 → `txidx` = 1.
- **Preemption:** mailbox 0 in REQ with base 0x200; `reqset[3]` with base 0x010 → one cycle of `traregbit` = 0, then `txidx` = 3. After `load`, a new lower request does not change `txidx` until XFER ends.
- **Abort:**
  - Abort mailbox 1 in REQ → `txabrt[1]`, then reselect.
  - Abort in XFER followed by `resettra` → `txabrt` after `resettra`.
  - Abort in XFER followed by `sucftranc` → `txdone` only.
- **Retry / single-shot:** `resettra` in XFER → without the macro, mailbox stays pending and `traregbit` rises again 2 cycles later. With the macro, `txfail` pulses and pending = 0.
- **Init and reset:** assert `initreqr` mid-XFER, then assert `reset` mid-REQ → all outputs 0, pending 0, no pulses emitted.

Source files
------------

// File: rtl/llc_txsched.sv
// llc_txsched: transmit mailbox scheduler, lowest arbitration key wins.
// Optional LLC_TXSCHED_SINGLESHOT_EN: failed attempts are dropped, not retried.
module llc_txsched #(
  parameter int NMBX = 4,
  parameter int IW   = $clog2(NMBX)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               initreqr,
  input  logic [NMBX-1:0]    reqset,
  input  logic [NMBX-1:0]    abtset,
  input  logic [29*NMBX-1:0] mbxid,
  input  logic [NMBX-1:0]    mbxext,
  input  logic               load,
  input  logic               sucftranc,
  input  logic               resettra,
  output logic               traregbit,
  output logic [28:0]        txid,
  output logic               txext,
  output logic [IW-1:0]      txidx,
  output logic [NMBX-1:0]    pending,
  output logic               busy,
  output logic [NMBX-1:0]    txdone,
  output logic [NMBX-1:0]    txabrt,
  output logic [NMBX-1:0]    txfail
);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    REQ,
    XFER
  } state_t;

  state_t state;
  logic   abtpend;

  logic [28:0] ids [NMBX];
  logic [29:0] key [NMBX];

  always_comb begin
    for (int i = 0; i < NMBX; i++) begin
      ids[i] = mbxid[29*i +: 29];
      key[i] = {ids[i][28:18], mbxext[i],
                mbxext[i] ? ids[i][17:0] : 18'b0};
    end
  end

  // Mailboxes being aborted this cycle do not compete.
  logic [NMBX-1:0] cand;
  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [29:0]     win_key;

  assign cand = pending & ~abtset;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_key = '1;
    for (int i = 0; i < NMBX; i++) begin
      if (cand[i] && (!win_vld || key[i] < win_key)) begin
        win_vld = 1'b1;
        win_idx = IW'(i);
        win_key = key[i];
      end
    end
  end

  logic [29:0] selkey;
  logic        preempt;

  assign selkey = {txid[28:18], txext,
                   txext ? txid[17:0] : 18'b0};

  always_comb begin
    preempt = 1'b0;
    for (int i = 0; i < NMBX; i++) begin
      if (pending[i] && IW'(i) != txidx
          && key[i] < selkey)
        preempt = 1'b1;
    end
  end

  logic lock;
  logic sel_abt;

  assign lock    = (state == REQ && load)
                 || state == XFER;
  assign sel_abt = abtset[txidx] && pending[txidx];

  logic [NMBX-1:0] pend_nxt;
  logic [NMBX-1:0] done_nxt;
  logic [NMBX-1:0] abrt_nxt;
`ifdef LLC_TXSCHED_SINGLESHOT_EN
  logic [NMBX-1:0] fail_nxt;
`endif

  always_comb begin
    pend_nxt = pending;
    done_nxt = '0;
    abrt_nxt = '0;
`ifdef LLC_TXSCHED_SINGLESHOT_EN
    fail_nxt = '0;
`endif
    for (int i = 0; i < NMBX; i++) begin
      if (abtset[i]) begin
        if (pending[i] && !(lock && IW'(i) == txidx)) begin
          pend_nxt[i] = 1'b0;
          abrt_nxt[i] = 1'b1;
        end
      end else if (reqset[i]) begin
        pend_nxt[i] = 1'b1;
      end
    end
    if (state == XFER) begin
      if (sucftranc) begin
        pend_nxt[txidx] = 1'b0;
        done_nxt[txidx] = 1'b1;
      end else if (resettra) begin
        if (abtpend || abtset[txidx]) begin
          pend_nxt[txidx] = 1'b0;
          abrt_nxt[txidx] = 1'b1;
        end else begin
`ifdef LLC_TXSCHED_SINGLESHOT_EN
          pend_nxt[txidx] = 1'b0;
          fail_nxt[txidx] = 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      abtpend   <= 1'b0;
      pending   <= '0;
      traregbit <= 1'b0;
      busy      <= 1'b0;
      txid      <= '0;
      txext     <= 1'b0;
      txidx     <= '0;
      txdone    <= '0;
      txabrt    <= '0;
`ifdef LLC_TXSCHED_SINGLESHOT_EN
      txfail    <= '0;
`endif
    end else if (initreqr) begin
      state     <= IDLE;
      abtpend   <= 1'b0;
      pending   <= '0;
      traregbit <= 1'b0;
      busy      <= 1'b0;
      txid      <= '0;
      txext     <= 1'b0;
      txidx     <= '0;
      txdone    <= '0;
      txabrt    <= '0;
`ifdef LLC_TXSCHED_SINGLESHOT_EN
      txfail    <= '0;
`endif
    end else begin
      pending <= pend_nxt;
      txdone  <= done_nxt;
      txabrt  <= abrt_nxt;
`ifdef LLC_TXSCHED_SINGLESHOT_EN
      txfail  <= fail_nxt;
`endif
      unique case (state)
        IDLE: begin
          if (|pend_nxt)
            state <= SELECT;
        end
        SELECT: begin
          if (win_vld) begin
            txid      <= ids[win_idx];
            txext     <= mbxext[win_idx];
            txidx     <= win_idx;
            traregbit <= 1'b1;
            state     <= REQ;
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (load) begin
            busy    <= 1'b1;
            abtpend <= sel_abt;
            state   <= XFER;
          end else if (preempt || sel_abt) begin
            traregbit <= 1'b0;
            state     <= SELECT;
          end
        end
        XFER: begin
          if (sucftranc || resettra) begin
            traregbit <= 1'b0;
            busy      <= 1'b0;
            abtpend   <= 1'b0;
            state     <= IDLE;
          end else if (abtset[txidx]) begin
            abtpend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef LLC_TXSCHED_SINGLESHOT_EN
  assign txfail = '0;
`endif

endmodule

// File: tb/tb_llc_txsched.sv
// tb_llc_txsched: directed vectors for the transmit mailbox scheduler.
// Expected values are hand-derived from the cycle timing of the block.
module tb_llc_txsched;

  localparam int NMBX = 4;
  localparam int IW   = 2;

  logic               clock = 1'b0;
  logic               reset;
  logic               initreqr;
  logic [NMBX-1:0]    reqset;
  logic [NMBX-1:0]    abtset;
  logic [29*NMBX-1:0] mbxid;
  logic [NMBX-1:0]    mbxext;
  logic               load;
  logic               sucftranc;
  logic               resettra;
  logic               traregbit;
  logic [28:0]        txid;
  logic               txext;
  logic [IW-1:0]      txidx;
  logic [NMBX-1:0]    pending;
  logic               busy;
  logic [NMBX-1:0]    txdone;
  logic [NMBX-1:0]    txabrt;
  logic [NMBX-1:0]    txfail;

  int nvec = 0;
  int nerr = 0;

  llc_txsched #(.NMBX(NMBX), .IW(IW)) dut (
    .clock     (clock),
    .reset     (reset),
    .initreqr  (initreqr),
    .reqset    (reqset),
    .abtset    (abtset),
    .mbxid     (mbxid),
    .mbxext    (mbxext),
    .load      (load),
    .sucftranc (sucftranc),
    .resettra  (resettra),
    .traregbit (traregbit),
    .txid      (txid),
    .txext     (txext),
    .txidx     (txidx),
    .pending   (pending),
    .busy      (busy),
    .txdone    (txdone),
    .txabrt    (txabrt),
    .txfail    (txfail)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [28:0] sid(input logic [10:0] b);
    return {b, 18'h0};
  endfunction

  task automatic setid(input int i, input logic [28:0] v,
                       input logic e);
    mbxid[29*i +: 29] = v;
    mbxext[i] = e;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clean();
    initreqr = 1'b1;
    step();
    initreqr = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    initreqr = 1'b0;
    reqset = '0;
    abtset = '0;
    mbxid = '0;
    mbxext = '0;
    load = 1'b0;
    sucftranc = 1'b0;
    resettra = 1'b0;
    repeat (2) step();
    check("rst_trareg", 32'(traregbit), 0);
    check("rst_pend", 32'(pending), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_txid", 32'(txid), 0);
    check("rst_txidx", 32'(txidx), 0);
    reset = 1'b1;
    step();

    // single request
    setid(1, sid(11'h123), 1'b0);
    reqset = 4'b0010;
    step();
    reqset = '0;
    check("sgl_pend", 32'(pending), 4'b0010);
    check("sgl_trareg0", 32'(traregbit), 0);
    step();
    check("sgl_trareg1", 32'(traregbit), 1);
    check("sgl_txidx", 32'(txidx), 1);
    check("sgl_txid", 32'(txid), 32'(sid(11'h123)));
    load = 1'b1;
    step();
    load = 1'b0;
    check("sgl_busy", 32'(busy), 1);
    sucftranc = 1'b1;
    step();
    sucftranc = 1'b0;
    check("sgl_done", 32'(txdone), 4'b0010);
    check("sgl_pend0", 32'(pending), 0);
    check("sgl_trareg_end", 32'(traregbit), 0);
    check("sgl_busy_end", 32'(busy), 0);
    step();
    check("sgl_done_1cyc", 32'(txdone), 0);

    // priority
    setid(0, sid(11'h100), 1'b0);
    setid(2, sid(11'h080), 1'b0);
    reqset = 4'b0101;
    step();
    reqset = '0;
    step();
    check("pri_txidx2", 32'(txidx), 2);
    setid(3, sid(11'h080) | 29'h1, 1'b1);
    reqset = 4'b1000;
    step();
    reqset = '0;
    step();
    check("pri_ext_lose", 32'(txidx), 2);
    check("pri_trareg", 32'(traregbit), 1);
    load = 1'b1;
    step();
    load = 1'b0;
    sucftranc = 1'b1;
    step();
    sucftranc = 1'b0;
    check("pri_done2", 32'(txdone), 4'b0100);
    step();
    step();
    check("pri_txidx3", 32'(txidx), 3);
    check("pri_txext3", 32'(txext), 1);

    // retry / single-shot
    load = 1'b1;
    step();
    load = 1'b0;
    resettra = 1'b1;
    step();
    resettra = 1'b0;
    check("rty_trareg0", 32'(traregbit), 0);
`ifdef LLC_TXSCHED_SINGLESHOT_EN
    check("rty_pend", 32'(pending), 4'b0001);
    check("rty_fail", 32'(txfail), 4'b1000);
`else
    check("rty_pend", 32'(pending), 4'b1001);
    check("rty_fail", 32'(txfail), 0);
`endif
    step();
    check("rty_gap", 32'(traregbit), 0);
    step();
    check("rty_trareg1", 32'(traregbit), 1);
`ifdef LLC_TXSCHED_SINGLESHOT_EN
    check("rty_txidx", 32'(txidx), 0);
`else
    check("rty_txidx", 32'(txidx), 3);
`endif
    clean();
    check("ini_pend", 32'(pending), 0);

    // equal keys
    setid(1, sid(11'h055), 1'b0);
    setid(3, sid(11'h055), 1'b0);
    reqset = 4'b1010;
    step();
    reqset = '0;
    step();
    check("eq_txidx", 32'(txidx), 1);
    clean();

    // preemption
    setid(0, sid(11'h200), 1'b0);
    setid(3, sid(11'h010), 1'b0);
    reqset = 4'b0001;
    step();
    reqset = '0;
    step();
    check("pre_txidx0", 32'(txidx), 0);
    reqset = 4'b1000;
    step();
    reqset = '0;
    check("pre_hold", 32'(traregbit), 1);
    step();
    check("pre_drop", 32'(traregbit), 0);
    step();
    check("pre_rise", 32'(traregbit), 1);
    check("pre_txidx3", 32'(txidx), 3);
    load = 1'b1;
    step();
    load = 1'b0;
    setid(1, sid(11'h001), 1'b0);
    reqset = 4'b0010;
    step();
    reqset = '0;
    step();
    check("pre_locked", 32'(txidx), 3);
    check("pre_busy", 32'(busy), 1);
    sucftranc = 1'b1;
    step();
    sucftranc = 1'b0;
    check("pre_done", 32'(txdone), 4'b1000);
    clean();

    // abort in REQ
    setid(1, sid(11'h050), 1'b0);
    setid(2, sid(11'h060), 1'b0);
    reqset = 4'b0110;
    step();
    reqset = '0;
    step();
    check("abr_txidx1", 32'(txidx), 1);
    abtset = 4'b0010;
    step();
    abtset = '0;
    check("abr_abrt", 32'(txabrt), 4'b0010);
    check("abr_pend", 32'(pending), 4'b0100);
    check("abr_drop", 32'(traregbit), 0);
    step();
    check("abr_resel", 32'(txidx), 2);
    check("abr_rise", 32'(traregbit), 1);

    // abort in XFER then resettra
    load = 1'b1;
    step();
    load = 1'b0;
    abtset = 4'b0100;
    step();
    abtset = '0;
    check("abx_nopulse", 32'(txabrt), 0);
    check("abx_pend", 32'(pending), 4'b0100);
    resettra = 1'b1;
    step();
    resettra = 1'b0;
    check("abx_abrt", 32'(txabrt), 4'b0100);
    check("abx_pend0", 32'(pending), 0);
    check("abx_trareg", 32'(traregbit), 0);

    // abort in XFER then success
    setid(0, sid(11'h070), 1'b0);
    reqset = 4'b0001;
    step();
    reqset = '0;
    step();
    load = 1'b1;
    step();
    load = 1'b0;
    abtset = 4'b0001;
    step();
    abtset = '0;
    sucftranc = 1'b1;
    step();
    sucftranc = 1'b0;
    check("abs_done", 32'(txdone), 4'b0001);
    check("abs_noabrt", 32'(txabrt), 0);
    step();
    check("abs_noabrt2", 32'(txabrt), 0);
    check("abs_pend", 32'(pending), 0);

    // reqset and abtset together on idle mailbox
    reqset = 4'b0001;
    abtset = 4'b0001;
    step();
    reqset = '0;
    abtset = '0;
    check("ra_pend", 32'(pending), 0);
    check("ra_abrt", 32'(txabrt), 0);

    // initreqr mid-XFER
    reqset = 4'b0001;
    step();
    reqset = '0;
    step();
    load = 1'b1;
    step();
    load = 1'b0;
    check("ini_busy1", 32'(busy), 1);
    initreqr = 1'b1;
    step();
    initreqr = 1'b0;
    check("ini_trareg", 32'(traregbit), 0);
    check("ini_busy", 32'(busy), 0);
    check("ini_pend0", 32'(pending), 0);
    check("ini_txid", 32'(txid), 0);
    check("ini_done", 32'(txdone), 0);
    step();
    check("ini_idle", 32'(traregbit), 0);

    // async reset mid-REQ
    reqset = 4'b0010;
    step();
    reqset = '0;
    step();
    check("ar_trareg1", 32'(traregbit), 1);
    reset = 1'b0;
    #1;
    check("ar_trareg", 32'(traregbit), 0);
    check("ar_pend", 32'(pending), 0);
    check("ar_txidx", 32'(txidx), 0);
    check("ar_txid", 32'(txid), 0);
    step();
    reset = 1'b1;
    step();
    check("ar_after", 32'(traregbit), 0);
    check("ar_abrt", 32'(txabrt), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
